multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states, one state per clock.
- Drives the datapath control lines, with a wait-state handshake to instruction/data memory.
- Sits between the instruction register (op source) and the shared datapath (PC, register file, ALU, memory mux).

Parameters:
- OP_RTYPE, 6'd0, R-type opcode
- OP_LW, 6'd35, load-word opcode
- OP_SW, 6'd43, store-word opcode
- OP_BEQ, 6'd4, branch-equal opcode
- OP_J, 6'd2, jump opcode
- OP_ADDI, 6'd8, add-immediate opcode
- ALUOP_W, 3, width of alu_op
- ALUOP_ADD, 0, alu_op code for add
- ALUOP_SUB, 1, alu_op code for subtract
- ALUOP_FUNCT, 2, alu_op code for "decode funct field"

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  opcode from IR; valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  2  00 ALU result, 01 ALUOut reg, 10 jump target
- i_or_d  out  1  0 memory address = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- mem_to_reg  out  1  writeback source: 1 MDR, 0 ALUOut
- reg_dst  out  1  1 rd, 0 rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 regA
- alu_src_b  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  ALUOP_W  ALU operation select
- instr_done  out  1  one-cycle pulse on final state of each instruction
- illegal_op  out  1  sticky; opcode not recognised
- state  out  4  current state encoding, for debug

Behaviour:
- The reset is asynchronous active-low and takes effect on the falling edge of rst_n: state goes to RST (0). All outputs are 0 while in RST.
- RST always moves to FETCH on the next edge.
- State register updates on the rising edge of clk.
- Outputs decode combinationally from state; they are Mealy on mem_ready only where noted.
- Any output not listed for a state is 0.
- State encodings:
  - RST 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5
  - MEM_WR 6, EXEC_R 7, R_WB 8, BRANCH 9, JUMP 10, EXEC_I 11
  - I_WB 12, TRAP 13
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - ir_write=pc_write=mem_ready (Mealy).
  - Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=ADD.
  - Next state: LW/SW->MEM_ADDR, RTYPE->EXEC_R, BEQ->BRANCH, J->JUMP, ADDI->EXEC_I, any other->TRAP.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=ADD.
  - Next state: LW->MEM_RD, SW->MEM_WR.
  - op is re-read here; IR is stable because ir_write is 0 outside FETCH.
- MEM_RD: mem_read=1, i_or_d=1; waits while mem_ready=0, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; then FETCH.
- MEM_WR:
  - Outputs: mem_write=1, i_or_d=1.
  - Waits while mem_ready=0.
  - instr_done=mem_ready (Mealy); goes to FETCH when mem_ready=1.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=FUNCT; then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_source=01, instr_done=1; then FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1; then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=ADD; then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; then FETCH.
- TRAP:
  - illegal_op=1; all other outputs are 0.
  - Terminal: the block stays in TRAP until rst_n is asserted.
- Latency with mem_ready held at 1:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
- Each memory wait cycle (FETCH, MEM_RD, MEM_WR) adds one cycle.
- mem_read and mem_write are never asserted together.
- reg_write and any memory request are never asserted together.
- Reset mid-instruction: the block returns to RST immediately. No partial writeback occurs after reset deassertion, and the next instruction starts from FETCH.
- Unused state encodings 14 and 15 go to RST on the next edge, with all outputs 0.

Test Plan:
- Reset, then op=0 (R-type) with mem_ready=1:
  - state sequence 0,1,2,7,8,1
  - reg_write=1 and reg_dst=1 only in state 8
  - instr_done pulses once
- op=35 (lw) with mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEM_RD:
  - states 1,1,1,2,3,4,4,4,4,5
  - ir_write/pc_write high only in the third FETCH cycle
  - total 10 cycles
- op=43 (sw), then op=4 (beq), then op=2 (j), with mem_ready=1:
  - sw: mem_write high for 1 cycle
  - beq: pc_write_cond=1, alu_op=1
  - j: pc_write=1, pc_source=10
  - lengths 4, 3, 3 cycles
- op=54 (undefined) after FETCH:
  - DECODE goes to TRAP (13); illegal_op stays 1 for 20 cycles with all other outputs 0
  - asserting rst_n low clears illegal_op asynchronously (within the same cycle)
- rst_n pulsed low while in MEM_WB of lw:
  - state goes to 0 before the next edge; reg_write drops immediately
  - after release, the sequence restarts at FETCH
- op=8 (addi) with random mem_ready:
  - reg_write only in state 12, with reg_dst=0 and alu_src_b=10 in state 11
  - mem_read and mem_write are never both 1 in any cycle

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle instruction sequencer driving datapath control lines with a memory wait-state handshake
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_LW = 6'd35,
  parameter logic [5:0] OP_SW = 6'd43,
  parameter logic [5:0] OP_BEQ = 6'd4,
  parameter logic [5:0] OP_J = 6'd2,
  parameter logic [5:0] OP_ADDI = 6'd8,
  parameter int ALUOP_W = 3,
  parameter logic [ALUOP_W-1:0] ALUOP_ADD = ALUOP_W'(0),
  parameter logic [ALUOP_W-1:0] ALUOP_SUB = ALUOP_W'(1),
  parameter logic [ALUOP_W-1:0] ALUOP_FUNCT = ALUOP_W'(2)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [5:0] op,
  input  logic mem_ready,
  output logic pc_write,
  output logic pc_write_cond,
  output logic [1:0] pc_source,
  output logic i_or_d,
  output logic mem_read,
  output logic mem_write,
  output logic ir_write,
  output logic mem_to_reg,
  output logic reg_dst,
  output logic reg_write,
  output logic alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic instr_done,
  output logic illegal_op,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    RST = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_RD = 4'd4,
    MEM_WB = 4'd5, MEM_WR = 4'd6, EXEC_R = 4'd7, R_WB = 4'd8, BRANCH = 4'd9,
    JUMP = 4'd10, EXEC_I = 4'd11, I_WB = 4'd12, TRAP = 4'd13
  } state_t;
  state_t r_state;
  assign state = r_state;
  // sequencer: one state per clock, memory states hold until mem_ready, TRAP is terminal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RST;
    else begin
      case (r_state)
        RST: r_state <= FETCH;
        FETCH: r_state <= mem_ready ? DECODE : FETCH;
        DECODE: r_state <= (op == OP_LW || op == OP_SW) ? MEM_ADDR :
                           op == OP_RTYPE ? EXEC_R :
                           op == OP_BEQ ? BRANCH :
                           op == OP_J ? JUMP :
                           op == OP_ADDI ? EXEC_I : TRAP;
        MEM_ADDR: r_state <= op == OP_LW ? MEM_RD : op == OP_SW ? MEM_WR : TRAP;
        MEM_RD: r_state <= mem_ready ? MEM_WB : MEM_RD;
        MEM_WR: r_state <= mem_ready ? FETCH : MEM_WR;
        EXEC_R: r_state <= R_WB;
        EXEC_I: r_state <= I_WB;
        MEM_WB, R_WB, BRANCH, JUMP, I_WB: r_state <= FETCH;
        TRAP: r_state <= TRAP;
        default: r_state <= RST;
      endcase
    end
  end
  // control decode from state; only FETCH and MEM_WR look at mem_ready
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    pc_source = 2'b00;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = ALUOP_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      DECODE: alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d = 1'b1;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d = 1'b1;
        instr_done = mem_ready;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_FUNCT;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source = 2'b01;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_source = 2'b10;
        instr_done = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      I_WB: begin
        reg_write = 1'b1;
        instr_done = 1'b1;
      end
      TRAP: illegal_op = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle vectors scored against a queue of expected state/control words
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [5:0] op = 6'd0;
  logic mem_ready = 1'b1;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;
  typedef struct packed {
    logic pw, pwc;
    logic [1:0] ps;
    logic iord, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic done, ill;
  } outs_t;
  typedef struct packed {
    logic [3:0] st;
    outs_t o;
  } item_t;
  item_t sb[$];
  item_t it;
  int n_vec = 0;
  int n_bad = 0;
  logic r;
  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );
  always #5 clk = ~clk;
  function automatic outs_t exp_out(input logic [3:0] s, input logic rdy);
    outs_t o = '0;
    case (s)
      4'd1: begin o.mr = 1; o.asb = 2'b01; o.pw = rdy; o.irw = rdy; end
      4'd2: o.asb = 2'b11;
      4'd3: begin o.asa = 1; o.asb = 2'b10; end
      4'd4: begin o.mr = 1; o.iord = 1; end
      4'd5: begin o.rw = 1; o.m2r = 1; o.done = 1; end
      4'd6: begin o.mw = 1; o.iord = 1; o.done = rdy; end
      4'd7: begin o.asa = 1; o.aop = 3'd2; end
      4'd8: begin o.rw = 1; o.rd = 1; o.done = 1; end
      4'd9: begin o.asa = 1; o.aop = 3'd1; o.pwc = 1; o.ps = 2'b01; o.done = 1; end
      4'd10: begin o.pw = 1; o.ps = 2'b10; o.done = 1; end
      4'd11: begin o.asa = 1; o.asb = 2'b10; end
      4'd12: begin o.rw = 1; o.done = 1; end
      4'd13: o.ill = 1;
      default: ;
    endcase
    return o;
  endfunction
  function automatic outs_t act();
    return {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op};
  endfunction
  task automatic cyc(input logic [5:0] o, input logic rdy, input logic [3:0] s);
    op = o;
    mem_ready = rdy;
    sb.push_back({s, exp_out(s, rdy)});
    @(posedge clk);
    #1;
  endtask
  task automatic cyc_rst(input logic [5:0] o, input logic rdy, input logic [3:0] s);
    op = o;
    mem_ready = rdy;
    sb.push_back({s, exp_out(s, rdy)});
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  // monitor: reset check on every reset assertion, scoreboard pop on every falling clock edge
  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      n_vec++;
      if (state !== 4'd0 || act() !== outs_t'(0)) begin
        n_bad++;
        $display("FAIL reset: state=%0d outs=%h, expected state=0 outs=0", state, act());
      end
    end else if (sb.size() > 0) begin
      it = sb.pop_front();
      n_vec++;
      if (state !== it.st || act() !== it.o) begin
        n_bad++;
        $display("FAIL step @%0t: state=%0d outs=%h, expected state=%0d outs=%h", $time, state, act(), it.st, it.o);
      end
      n_vec++;
      if ((mem_read && mem_write) || (reg_write && (mem_read || mem_write))) begin
        n_bad++;
        $display("FAIL exclusive @%0t: mr=%b mw=%b rw=%b, expected no overlap", $time, mem_read, mem_write, reg_write);
      end
    end
  end
  initial begin
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 1, 0); cyc(0, 1, 1); cyc(0, 1, 2); cyc(0, 1, 7); cyc(0, 1, 8);
    cyc(35, 0, 1); cyc(35, 0, 1); cyc(35, 1, 1); cyc(35, 1, 2); cyc(35, 1, 3);
    cyc(35, 0, 4); cyc(35, 0, 4); cyc(35, 0, 4); cyc(35, 1, 4); cyc(35, 1, 5);
    cyc(43, 1, 1); cyc(43, 1, 2); cyc(43, 1, 3); cyc(43, 1, 6);
    cyc(4, 1, 1); cyc(4, 1, 2); cyc(4, 1, 9);
    cyc(2, 1, 1); cyc(2, 1, 2); cyc(2, 1, 10);
    cyc(54, 1, 1); cyc(54, 1, 2);
    for (int i = 0; i < 20; i++) cyc(54, 1'(i), 13);
    cyc_rst(54, 1, 13);
    cyc(35, 1, 0); cyc(35, 1, 1); cyc(35, 1, 2); cyc(35, 1, 3); cyc(35, 1, 4);
    cyc_rst(35, 1, 5);
    cyc(8, 1, 0);
    for (int k = 0; k < 4; k++) begin
      do begin
        r = 1'($urandom_range(0, 1));
        cyc(8, r, 1);
      end while (!r);
      cyc(8, 1'($urandom_range(0, 1)), 2);
      cyc(8, 1'($urandom_range(0, 1)), 11);
      cyc(8, 1'($urandom_range(0, 1)), 12);
    end
    cyc(8, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
